// File: rtl/ram_arbiter.sv
// Arbitrates one shared RAM port between instruction fetch and data load/store; one transaction in flight.
// Grant on the edge after a request, strobes from latched values, done pulse the cycle after ACCESS/ERROR/timeout.
package ram_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } imem_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;
endpackage

module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output imem_t       i_resp,
   output logic        i_err,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_sel,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        ram_ren,
   output logic        ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic [3:0]  ram_sel,
   input  logic [31:0] ram_rdata,
   input  ramstate_t   ram_state
);
   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

   state_t        r_state;
   logic          r_last_data;
   logic          r_ren;
   logic          r_wen;
   logic          r_illegal;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_sel;
   logic [CW-1:0] r_cnt;
   imem_t         r_i_resp;
   logic          r_i_err;
   logic          r_d_done;
   logic [31:0]   r_d_rdata;
   logic          r_d_err;

   logic w_f_pend;
   logic w_d_pend;
   logic w_grant_d;
   logic w_grant_f;
   logic w_ok;
   logic w_finish;

   // A requester still showing its done pulse is being released, not re-requesting.
   assign w_f_pend  = i_req & ~r_i_resp.valid;
   assign w_d_pend  = (d_read | d_write) & ~r_d_done;
   assign w_grant_d = w_d_pend & (~w_f_pend | ~r_last_data);
   assign w_grant_f = w_f_pend & ~w_grant_d;

   assign w_ok     = ~r_illegal & (ram_state == ACCESS);
   assign w_finish = r_illegal | (ram_state == ACCESS) | (ram_state == ERROR) | (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last_data <= 1'b0;
         r_ren       <= 1'b0;
         r_wen       <= 1'b0;
         r_illegal   <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_sel       <= '0;
         r_cnt       <= '0;
         r_i_resp    <= '0;
         r_i_err     <= 1'b0;
         r_d_done    <= 1'b0;
         r_d_rdata   <= '0;
         r_d_err     <= 1'b0;
      end else begin
         r_i_resp.valid <= 1'b0;
         r_i_err        <= 1'b0;
         r_d_done       <= 1'b0;
         r_d_err        <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_state     <= DATA;
                  r_last_data <= 1'b1;
                  r_addr      <= d_addr;
                  r_wdata     <= d_wdata;
                  r_sel       <= d_sel;
                  r_illegal   <= d_read & d_write;
                  r_ren       <= d_read & ~d_write;
                  r_wen       <= d_write & ~d_read;
                  r_cnt       <= '0;
               end else if (w_grant_f) begin
                  r_state     <= FETCH;
                  r_last_data <= 1'b0;
                  r_addr      <= i_addr;
                  r_wdata     <= '0;
                  r_sel       <= 4'hF;
                  r_illegal   <= 1'b0;
                  r_ren       <= 1'b1;
                  r_wen       <= 1'b0;
                  r_cnt       <= '0;
               end
            end
            FETCH, DATA: begin
               if (w_finish) begin
                  r_state <= IDLE;
                  r_ren   <= 1'b0;
                  r_wen   <= 1'b0;
                  // Errors, timeouts and illegal requests all return zero data.
                  if (r_state == FETCH) begin
                     r_i_resp.valid <= 1'b1;
                     r_i_resp.data  <= w_ok ? ram_rdata : 32'd0;
                     r_i_err        <= ~w_ok;
                  end else begin
                     r_d_done  <= 1'b1;
                     r_d_rdata <= w_ok ? ram_rdata : 32'd0;
                     r_d_err   <= ~w_ok;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ren   <= 1'b0;
               r_wen   <= 1'b0;
            end
         endcase
      end
   end

   assign i_resp    = r_i_resp;
   assign i_err     = r_i_err;
   assign d_done    = r_d_done;
   assign d_rdata   = r_d_rdata;
   assign d_err     = r_d_err;
   assign ram_ren   = r_ren;
   assign ram_wen   = r_wen;
   assign ram_addr  = r_addr;
   assign ram_wdata = r_wdata;
   assign ram_sel   = r_sel;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the fetch/data RAM arbiter.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   localparam int TO = 8;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   imem_t       i_resp;
   logic        i_err;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_sel;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_sel;
   logic [31:0] ram_rdata;
   ramstate_t   ram_state;

   int n_cmp = 0;
   int n_bad = 0;
   bit last_d = 1'b0;   // model: previous grant went to data
   int mask   = 0;      // model: requester whose done pulse is showing (0 none, 1 fetch, 2 data)
   bit glog[$];         // model: grant history, 1 = data

   ram_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_resp(i_resp), .i_err(i_err),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_sel(ram_sel), .ram_rdata(ram_rdata), .ram_state(ram_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one granted transaction starting in the current (IDLE) cycle.
   // w = wait cycles before the terminal ram_state 'kind'; rdv = RAM data on the terminal cycle.
   task automatic txn(input int w, input ramstate_t kind, input logic [31:0] rdv,
                      input bit rnd, input bit hold);
      bit          f_p, d_p, win_d, ill, ok, e_ren, e_wen;
      int          c;
      logic [31:0] e_addr, e_wd, e_dat;
      logic [3:0]  e_sel;
      f_p = i_req && mask != 1;
      d_p = (d_read || d_write) && mask != 2;
      if (!f_p && !d_p) begin
         tick();
         mask = 0;
         chk("gap_done", 32'({i_resp.valid, d_done}), 32'd0);
         f_p = i_req;
         d_p = d_read || d_write;
      end
      chk("idle_strobe", 32'({ram_ren, ram_wen}), 32'd0);
      if (!f_p && !d_p) return;
      win_d  = d_p && (!f_p || !last_d);
      last_d = win_d;
      glog.push_back(win_d);
      if (win_d) begin
         ill    = d_read && d_write;
         e_ren  = d_read && !d_write;
         e_wen  = d_write && !d_read;
         e_addr = d_addr;
         e_wd   = d_wdata;
         e_sel  = d_sel;
      end else begin
         ill    = 1'b0;
         e_ren  = 1'b1;
         e_wen  = 1'b0;
         e_addr = i_addr;
         e_wd   = 32'd0;
         e_sel  = 4'hF;
      end
      c     = ill ? 1 : ((w + 1 < TO) ? w + 1 : TO);
      ok    = !ill && (w + 1 <= TO) && (kind == ACCESS);
      e_dat = ok ? rdv : 32'd0;
      for (int k = 1; k <= c; k++) begin
         tick();
         if (k <= w) ram_state = (rnd && $urandom_range(0, 1) == 1) ? FREE : BUSY;
         else        ram_state = kind;
         ram_rdata = (k == c) ? rdv : $urandom;
         chk("ram_ren", 32'(ram_ren), 32'(e_ren));
         chk("ram_wen", 32'(ram_wen), 32'(e_wen));
         chk("ram_addr", ram_addr, e_addr);
         chk("ram_sel", 32'(ram_sel), 32'(e_sel));
         if (e_wen) chk("ram_wdata", ram_wdata, e_wd);
         chk("early_done", 32'({i_resp.valid, d_done}), 32'd0);
      end
      tick();
      ram_state = FREE;
      if (win_d) begin
         chk("d_done", 32'(d_done), 32'd1);
         chk("d_err", 32'(d_err), 32'(!ok));
         chk("d_rdata", d_rdata, e_dat);
         chk("i_valid_idle", 32'(i_resp.valid), 32'd0);
      end else begin
         chk("i_valid", 32'(i_resp.valid), 32'd1);
         chk("i_err", 32'(i_err), 32'(!ok));
         chk("i_data", i_resp.data, e_dat);
         chk("d_done_idle", 32'(d_done), 32'd0);
      end
      chk("done_strobe", 32'({ram_ren, ram_wen}), 32'd0);
      if (!hold) begin
         if (win_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
         end else begin
            i_req = 1'b0;
         end
      end
      mask = win_d ? 2 : 1;
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
      d_addr = '0; d_wdata = '0; d_sel = '0; ram_rdata = '0; ram_state = FREE;

      // Reset state
      tick();
      tick();
      chk("rst_strobes", 32'({ram_ren, ram_wen}), 32'd0);
      chk("rst_i_resp", 32'({i_resp.valid, i_err}), 32'd0);
      chk("rst_i_data", i_resp.data, 32'd0);
      chk("rst_d_out", 32'({d_done, d_err}), 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_ram_sel", 32'(ram_sel), 32'd0);
      rst = 1'b0;

      // Single fetch, zero wait
      i_req = 1'b1; i_addr = 32'h100;
      txn(0, ACCESS, 32'hDEADBEEF, 1'b0, 1'b0);

      // Contention: both held across four transactions
      i_req = 1'b1; i_addr = 32'h200;
      d_read = 1'b1; d_addr = 32'h300; d_sel = 4'hF;
      for (int t = 0; t < 4; t++) txn(0, ACCESS, $urandom, 1'b0, 1'b1);
      for (int t = 0; t < 4; t++) chk("grant_order", 32'(glog[t + 1]), 32'((t % 2) == 0));
      i_req = 1'b0; d_read = 1'b0;

      // Store with three BUSY cycles
      d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_sel = 4'b0011;
      txn(3, ACCESS, 32'hCAFEF00D, 1'b0, 1'b0);

      // RAM error on a load
      d_read = 1'b1; d_addr = 32'h44;
      txn(0, ERROR, 32'h55AA55AA, 1'b0, 1'b0);

      // Fetch timeout with RAM stuck BUSY
      i_req = 1'b1; i_addr = 32'h400;
      txn(20, ACCESS, 32'h11111111, 1'b0, 1'b0);

      // Illegal read+write
      d_read = 1'b1; d_write = 1'b1; d_addr = 32'h80;
      txn(0, ACCESS, 32'h22222222, 1'b0, 1'b0);

      // Reset in the middle of a waiting store
      tick();
      mask = 0;
      chk("pre_rst_done", 32'({i_resp.valid, d_done}), 32'd0);
      d_write = 1'b1; d_addr = 32'h90; d_wdata = 32'hA5A5A5A5; d_sel = 4'hC;
      tick();
      ram_state = BUSY;
      chk("busy_wen1", 32'(ram_wen), 32'd1);
      tick();
      chk("busy_wen2", 32'(ram_wen), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_strobes", 32'({ram_ren, ram_wen}), 32'd0);
      tick();
      chk("rst_no_done1", 32'(d_done), 32'd0);
      tick();
      chk("rst_no_done2", 32'(d_done), 32'd0);
      rst = 1'b0;
      mask = 0;
      last_d = 1'b0;
      txn(0, ACCESS, 32'h33333333, 1'b0, 1'b0);

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         ramstate_t kind;
         if (!i_req && $urandom_range(0, 1) == 1) begin
            i_req = 1'b1;
            i_addr = $urandom;
         end
         if (!d_read && !d_write && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 3))
               0, 1:    d_read = 1'b1;
               2:       d_write = 1'b1;
               default: begin d_read = 1'b1; d_write = 1'b1; end
            endcase
            d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom);
         end
         if (!i_req && !d_read && !d_write) begin
            i_req = 1'b1;
            i_addr = $urandom;
         end
         kind = ($urandom_range(0, 3) == 0) ? ERROR : ACCESS;
         txn(int'($urandom_range(0, 10)), kind, $urandom, 1'b1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
